time_set_ctrl: RTL and testbench

Button-driven time-setting controller for the binary clock. It debounces two front-panel buttons and sequences a set-hours/set-minutes edit session. It freezes the timekeeping counters while editing and issues a one-cycle load of the edited time. It also drives per-field blink masks so the display shows which field is being edited.

---
 rtl/time_set_ctrl.sv | 145 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Debounces mode/inc buttons and runs a set-hours/set-minutes edit session for the binary clock.
// Press-to-effect latency is DB_CYCLES+3 cycles; there is no backpressure and load is a one-cycle strobe.
module time_set_ctrl #(
    parameter int DB_CYCLES  = 20000,
    parameter int BLINK_HALF = 25000,
    parameter int TIMEOUT    = 3000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       hold,
    output logic       load,
    output logic [4:0] load_hours,
    output logic [5:0] load_minutes,
    output logic       blank_h,
    output logic       blank_m
);
    localparam int DBW = (DB_CYCLES  > 1) ? $clog2(DB_CYCLES)  : 1;
    localparam int BLW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TOW = (TIMEOUT    > 1) ? $clog2(TIMEOUT)    : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
    localparam logic [BLW-1:0] BL_MAX = BLW'(BLINK_HALF - 1);
    localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} state_t;

    // Bit 0 is the mode button, bit 1 the increment button.
    logic [1:0]     raw;
    logic [1:0]     sync1, sync2, db, db_d, press;
    logic [DBW-1:0] db_cnt [2];

    assign raw = {btn_inc, btn_mode};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            press <= db & ~db_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic           mode_ev, inc_ev;
    state_t         state;
    logic [4:0]     edit_h;
    logic [5:0]     edit_m;
    logic [TOW-1:0] idle_cnt;
    logic [BLW-1:0] blink_cnt;
    logic           phase;

    assign mode_ev = press[0];
    assign inc_ev  = press[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            hold      <= 1'b0;
            load      <= 1'b0;
            edit_h    <= '0;
            edit_m    <= '0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                RUN: begin
                    hold      <= 1'b0;
                    idle_cnt  <= '0;
                    blink_cnt <= '0;
                    phase     <= 1'b0;
                    if (mode_ev) begin
                        state  <= SET_H;
                        hold   <= 1'b1;
                        edit_h <= (cur_hours > 5'd23) ? 5'd0 : cur_hours;
                        edit_m <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
                    end
                end
                SET_H, SET_M: begin
                    // Mode beats inc in the same cycle; any accepted press beats the timeout.
                    if (mode_ev) begin
                        state     <= (state == SET_H) ? SET_M : COMMIT;
                        load      <= (state == SET_M);
                        idle_cnt  <= '0;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end else if (inc_ev) begin
                        if (state == SET_H)
                            edit_h <= (edit_h == 5'd23) ? 5'd0 : edit_h + 5'd1;
                        else
                            edit_m <= (edit_m == 6'd59) ? 6'd0 : edit_m + 6'd1;
                        idle_cnt  <= '0;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end else if (idle_cnt == TO_MAX) begin
                        state     <= RUN;
                        hold      <= 1'b0;
                        idle_cnt  <= '0;
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                        if (blink_cnt == BL_MAX) begin
                            phase     <= ~phase;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state <= RUN;
                    hold  <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign load_hours   = edit_h;
    assign load_minutes = edit_m;
    assign blank_h      = (state == SET_H) & phase;
    assign blank_m      = (state == SET_M) & phase;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed sessions with literal expectations plus a randomized phase,
// all cycles compared against a behavioural model of the button/edit rules.
module tb_time_set_ctrl;
    localparam int DB = 4;
    localparam int BL = 8;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hours = 5'd9;
    logic [5:0] cur_minutes = 6'd30;
    logic       hold, load, blank_h, blank_m;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;

    time_set_ctrl #(.DB_CYCLES(DB), .BLINK_HALF(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes),
        .hold(hold), .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
        .blank_h(blank_h), .blank_m(blank_m)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // Behavioural model: states 0=run 1=set hours 2=set minutes 3=commit.
    int          m_state;
    logic [4:0]  m_eh;
    logic [5:0]  m_em;
    int          m_age, m_bage;
    logic [1:0]  m_d1, m_d2, m_lvl, m_lvlp, m_press;
    logic [DB-1:0] m_hist [2];

    task automatic model_reset();
        m_state = 0; m_eh = 0; m_em = 0; m_age = 0; m_bage = 0;
        m_d1 = 0; m_d2 = 0; m_lvl = 0; m_lvlp = 0; m_press = 0;
        m_hist[0] = '0; m_hist[1] = '0;
    endtask

    task automatic model_step();
        logic [1:0] ev;
        ev = m_press;
        // Each synchronized sample lands two cycles after the raw pin; a level flips
        // once DB consecutive samples all disagree with it.
        for (int b = 0; b < 2; b++) m_hist[b] = {m_hist[b][DB-2:0], m_d2[b]};
        m_d2 = m_d1;
        m_d1 = {btn_inc, btn_mode};
        m_press = m_lvl & ~m_lvlp;
        m_lvlp = m_lvl;
        for (int b = 0; b < 2; b++)
            if (m_hist[b] == {DB{~m_lvl[b]}}) m_lvl[b] = ~m_lvl[b];

        case (m_state)
            0: if (ev[0]) begin
                m_state = 1;
                m_eh = (cur_hours > 23) ? 5'd0 : cur_hours;
                m_em = (cur_minutes > 59) ? 6'd0 : cur_minutes;
                m_age = 0; m_bage = 0;
            end
            1, 2: begin
                if (ev[0]) begin
                    m_state = (m_state == 1) ? 2 : 3;
                    m_age = 0; m_bage = 0;
                end else if (ev[1]) begin
                    if (m_state == 1) m_eh = 5'((m_eh + 1) % 24);
                    else              m_em = 6'((m_em + 1) % 60);
                    m_age = 0; m_bage = 0;
                end else if (m_age == TO - 1) begin
                    m_state = 0;
                end else begin
                    m_age++;
                    m_bage++;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    logic [14:0] got_v, exp_v;
    always @(negedge clk) begin
        exp_v = {m_state != 0, m_state == 3, m_eh, m_em,
                 (m_state == 1) && ((m_bage / BL) % 2 == 1),
                 (m_state == 2) && ((m_bage / BL) % 2 == 1)};
        got_v = {hold, load, load_hours, load_minutes, blank_h, blank_m};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            if (failures <= 30)
                $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, got_v, exp_v);
        end
    end

    int   load_cnt = 0;
    int   cap_h = -1, cap_m = -1, hold_at_load = -1;
    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt++;
            cap_h = int'(load_hours);
            cap_m = int'(load_minutes);
            hold_at_load = int'(hold);
        end
    end

    task automatic pulse(input int which, input int len);
        if (which == 0) btn_mode = 1'b1;
        else            btn_inc = 1'b1;
        repeat (len) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int old_h;
        repeat (3) @(negedge clk);
        check("reset_hold", hold, 0);
        check("reset_load", load, 0);
        check("reset_hours", load_hours, 0);
        check("reset_minutes", load_minutes, 0);
        check("reset_blank_h", blank_h, 0);
        check("reset_blank_m", blank_m, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Full session 09:30 -> 12:32
        pulse(0, 8);
        check("sess_hold", hold, 1);
        check("sess_cap_h", load_hours, 9);
        check("sess_cap_m", load_minutes, 30);
        repeat (3) pulse(1, 8);
        check("sess_inc_h", load_hours, 12);
        pulse(0, 8);
        pulse(1, 8);
        pulse(1, 8);
        check("sess_inc_m", load_minutes, 32);
        pulse(0, 8);
        check("sess_loads", load_cnt, 1);
        check("sess_load_h", cap_h, 12);
        check("sess_load_m", cap_m, 32);
        check("sess_commit_hold", hold_at_load, 1);
        check("sess_hold_after", hold, 0);

        // Wrap-around from 23:59
        cur_hours = 5'd23; cur_minutes = 6'd59;
        pulse(0, 8); pulse(1, 8); pulse(0, 8); pulse(1, 8); pulse(0, 8);
        check("wrap_loads", load_cnt, 2);
        check("wrap_h", cap_h, 0);
        check("wrap_m", cap_m, 0);

        // Debounce in SET_H
        cur_hours = 5'd5; cur_minutes = 6'd10;
        pulse(0, 8);
        check("db_entry_h", load_hours, 5);
        pulse(1, 3);
        check("db_glitch_h", load_hours, 5);
        btn_inc = 1'b1; repeat (6) @(negedge clk);
        btn_inc = 1'b0; @(negedge clk);
        btn_inc = 1'b1; repeat (2) @(negedge clk);
        btn_inc = 1'b0; @(negedge clk);
        btn_inc = 1'b1; @(negedge clk);
        btn_inc = 1'b0; repeat (14) @(negedge clk);
        check("db_chatter_h", load_hours, 6);

        // Simultaneous mode+inc: mode wins
        btn_mode = 1'b1; btn_inc = 1'b1;
        repeat (8) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        check("simul_h", load_hours, 6);
        check("simul_m", load_minutes, 10);
        check("simul_hold", hold, 1);

        // Timeout in SET_M
        repeat (TO) @(negedge clk);
        check("timeout_hold", hold, 0);
        check("timeout_loads", load_cnt, 2);

        // Reset mid-edit
        cur_hours = 5'd7; cur_minutes = 6'd45;
        pulse(0, 8); pulse(0, 8);
        check("midrst_pre_hold", hold, 1);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("midrst_hold", hold, 0);
        check("midrst_load", load, 0);
        check("midrst_h", load_hours, 0);
        check("midrst_m", load_minutes, 0);
        check("midrst_bh", blank_h, 0);
        check("midrst_bm", blank_m, 0);
        @(negedge clk); rst = 1'b1;
        repeat (50) @(negedge clk);
        check("midrst_loads", load_cnt, 2);

        // Blink pattern in SET_H
        btn_mode = 1'b1;
        for (int n = 0; n < 30 && hold !== 1'b1; n++) @(negedge clk);
        btn_mode = 1'b0;
        check("blink_entry", hold, 1);
        for (int i = 0; i < 40; i++) begin
            check("blink_h", blank_h, (i / 8) % 2);
            check("blink_m", blank_m, 0);
            @(negedge clk);
        end
        old_h = int'(load_hours);
        btn_inc = 1'b1;
        for (int n = 0; n < 30 && int'(load_hours) == old_h; n++) @(negedge clk);
        btn_inc = 1'b0;
        check("blink_inc_h", load_hours, 8);
        for (int i = 0; i < 8; i++) begin
            check("blink_after_inc", blank_h, 0);
            @(negedge clk);
        end
        check("blink_resume", blank_h, 1);

        // Randomized buttons, snapshots (including illegal values) and resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 3) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 40) == 0) begin
                cur_hours = 5'($urandom_range(0, 31));
                cur_minutes = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 900) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
